be8_sequencer: RTL
==================

BE8_SEQUENCER -- requirements
Module: be8_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of retired-instruction counter.
REQ-002 SHALL have parameter LAST_STEP, default 3: highest step index before wrap, legal range 1..3.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 run_mode  input  1  1 = free-run, 0 = single-step.
REQ-006 step_req  input  1  single-step request, level; rising edge counts as one request.
REQ-007 resume  input  1  1-cycle pulse; leaves HALTED.
REQ-008 bus_in  input  8  CPU bus; opcode taken from bits [7:4].
REQ-009 carry_in, zero_in  input  1 each  ALU flag sources.
REQ-010 hlt  input  1  decoded halt line, active-high.
REQ-011 ii_n  input  1  decoded instruction-register load, active-low.
REQ-012 fi_n  input  1  decoded flag-register load, active-low.
REQ-013 nxt_n  input  1  decoded early end-of-instruction, active-low.
REQ-014 opcode  output  4  instruction register, drives decoder OPCODE.
REQ-015 flags  output  2  {carry, zero}, drives decoder FLAGS.
REQ-016 step  output  2  microstep counter, drives decoder STEP.
REQ-017 adv  output  1  datapath advance enable, registered.
REQ-018 halted  output  1  1 while in HALTED.
REQ-019 icount  output  CNT_W  retired-instruction counter.

Function
REQ-020 States SHALL be IDLE, RUN, WAIT_STEP, HALTED; encoding in shared package.
REQ-021 IDLE SHALL last exactly one cycle after reset release, then go to RUN if run_mode=1, else WAIT_STEP.
REQ-022 In RUN, adv SHALL be 1 every cycle; run_mode=0 sampled in RUN SHALL go to WAIT_STEP next cycle.
REQ-023 In WAIT_STEP, adv SHALL be 0 except for exactly one cycle after each detected step_req rising edge; run_mode=1 SHALL go to RUN.
REQ-024 An "advance cycle" is a cycle with adv=1; decoded inputs SHALL be acted on only in advance cycles.
REQ-025 Advance cycle, nxt_n=0 or step=LAST_STEP: step SHALL become 0 and icount SHALL increment, wrapping at 2^CNT_W-1 -> 0.
REQ-026 Advance cycle otherwise: step SHALL increment by 1.
REQ-027 Advance cycle, ii_n=0: opcode SHALL load bus_in[7:4] at the same edge.
REQ-028 Advance cycle, fi_n=0: flags SHALL load {carry_in, zero_in} at the same edge.
REQ-029 ii_n=0 and fi_n=0 together SHALL both load; nxt_n=0 with either SHALL also load.
REQ-030 Advance cycle, hlt=1: state SHALL go to HALTED; step, opcode and flags SHALL still update per REQ-025..028; adv SHALL be 0 from the next cycle.
REQ-031 HALTED SHALL ignore step_req and decoded inputs; resume=1 SHALL go to RUN or WAIT_STEP per run_mode.
REQ-032 step_req edges occurring in RUN or HALTED SHALL be discarded, not queued.
REQ-033 The edge detector SHALL register step_req; a level held high SHALL produce one advance only.

Reset
REQ-034 While rst_n=0: state=IDLE, step=0, opcode=0, flags=0, adv=0, halted=0, icount=0, step_req history=0.
REQ-035 Reset assertion mid-instruction SHALL abort immediately with no partial update on the following edge.

Structure
REQ-036 State enum, LAST_STEP default and flag bit positions SHALL live in package be8_pkg.
REQ-037 One sub-module be8_edge_det (registered rising-edge detector) SHALL be used for step_req; all else SHALL be flat.

Verification
REQ-038 Free-run, LDA-like: bus_in=0x1E at step 1 with ii_n=0 -> opcode=0x1 after that edge; step sequence 0,1,2,3,0; icount=1.
REQ-039 Early end: nxt_n=0 at step 2 -> step=0 next edge, icount increments, step 3 never seen.
REQ-040 Flags: carry_in=1, zero_in=0, fi_n=0 in advance cycle -> flags=2'b10; fi_n=0 with adv=0 -> flags unchanged.
REQ-041 Single-step: run_mode=0, step_req held high 10 cycles -> exactly one adv pulse, step 0->1.
REQ-042 Halt: hlt=1 at step 2 -> halted=1, adv=0 thereafter, step_req ignored; resume pulse -> adv=1 next cycle (run_mode=1).
REQ-043 Reset mid-run at step 2 -> all outputs zero asynchronously; IDLE one cycle after release, then step restarts at 0.

Source files
------------

// File: rtl/be8_pkg.sv
// Shared definitions for the BE8 microstep sequencer.
//   seq_state_t    : sequencer state encoding
//   LAST_STEP_DEF  : default highest microstep index before wrap
//   FLAG_C/FLAG_Z  : bit positions of carry and zero inside the flags bus
package be8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_STEP = 2'd2,
        ST_HALTED    = 2'd3
    } seq_state_t;

    localparam int unsigned LAST_STEP_DEF = 3;

    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/be8_edge_det.sv
// Registered rising-edge detector.
//   clk   : clock
//   rst_n : async active-low reset, clears the history register
//   sig   : level input
//   rise  : high for the cycle in which sig is 1 and was 0 on the previous edge
module be8_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/be8_sequencer.sv
// BE8 CPU microstep sequencer: holds instruction register, flags, microstep
// counter and retired-instruction counter, and gates datapath advance in
// free-run or single-step mode.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | one cycle after reset release, picks RUN or WAIT_STEP
// ST_RUN       | free-run, every cycle is an advance cycle
// ST_WAIT_STEP | single-step, one advance per step_req rising edge
// ST_HALTED    | stopped by hlt, waits for resume
//
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   run_mode                : 1 free-run, 0 single-step
//   step_req                : single-step request level (rising edge = request)
//   resume                  : one-cycle pulse to leave HALTED
//   bus_in                  : CPU bus, opcode from bits [7:4]
//   carry_in, zero_in       : ALU flag sources
//   hlt, ii_n, fi_n, nxt_n  : decoded control lines
//   opcode, flags, step     : decoder inputs
//   adv                     : registered datapath advance enable
//   halted                  : 1 while in HALTED
//   icount                  : retired-instruction counter
module be8_sequencer
    import be8_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned LAST_STEP = LAST_STEP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_mode,
    input  logic             step_req,
    input  logic             resume,
    input  logic [7:0]       bus_in,
    input  logic             carry_in,
    input  logic             zero_in,
    input  logic             hlt,
    input  logic             ii_n,
    input  logic             fi_n,
    input  logic             nxt_n,
    output logic [3:0]       opcode,
    output logic [1:0]       flags,
    output logic [1:0]       step,
    output logic             adv,
    output logic             halted,
    output logic [CNT_W-1:0] icount
);

    localparam logic [1:0] LAST_IDX = LAST_STEP[1:0];

    seq_state_t       state_q, state_d;
    logic             adv_q, adv_d;
    logic             step_rise;
    logic [1:0]       step_q;
    logic [3:0]       opcode_q;
    logic [1:0]       flags_q;
    logic [CNT_W-1:0] icount_q;
    logic             unused_bus;

    assign unused_bus = ^bus_in[3:0];

    be8_edge_det u_step_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (step_req),
        .rise  (step_rise)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            adv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adv_q   <= adv_d;
        end
    end

    // Next-state logic; hlt only counts in an advance cycle and wins over mode changes
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      state_d = run_mode ? ST_RUN : ST_WAIT_STEP;
            ST_RUN: begin
                if (adv_q && hlt)   state_d = ST_HALTED;
                else if (!run_mode) state_d = ST_WAIT_STEP;
            end
            ST_WAIT_STEP: begin
                if (adv_q && hlt)   state_d = ST_HALTED;
                else if (run_mode)  state_d = ST_RUN;
            end
            ST_HALTED: begin
                if (resume)         state_d = run_mode ? ST_RUN : ST_WAIT_STEP;
            end
            default:                state_d = ST_IDLE;
        endcase
    end

    // Output logic; adv is computed from the next state and registered, so
    // step_req edges seen outside WAIT_STEP are simply dropped.
    always_comb begin
        adv_d  = 1'b0;
        halted = (state_q == ST_HALTED);
        if (state_d == ST_RUN) begin
            adv_d = 1'b1;
        end else if (state_q == ST_WAIT_STEP && state_d == ST_WAIT_STEP) begin
            adv_d = step_rise;
        end
    end

    // Datapath registers, updated only in advance cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q   <= 2'd0;
            opcode_q <= 4'd0;
            flags_q  <= 2'b00;
            icount_q <= '0;
        end else if (adv_q) begin
            if (!nxt_n || step_q == LAST_IDX) begin
                step_q   <= 2'd0;
                icount_q <= icount_q + 1'b1;
            end else begin
                step_q   <= step_q + 2'd1;
            end
            if (!ii_n) begin
                opcode_q <= bus_in[7:4];
            end
            if (!fi_n) begin
                flags_q[FLAG_C] <= carry_in;
                flags_q[FLAG_Z] <= zero_in;
            end
        end
    end

    assign opcode = opcode_q;
    assign flags  = flags_q;
    assign step   = step_q;
    assign adv    = adv_q;
    assign icount = icount_q;

endmodule
